// File: rtl/uart_alu_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its UART RX/TX cores and adder.
// master: the sequencer side. slave: the environment (UART cores, adder).
interface uart_alu_frame_sequencer_if #(
    parameter int OP_W  = 32,
    parameter int RES_W = 32
);
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic [7:0]        tx_byte;
    logic              tx_start;
    logic              tx_busy;
    logic [2*OP_W-1:0] operAB;
    logic              alu_start;
    logic              alu_done;
    logic [RES_W-1:0]  result;
    logic              rx_status;
    logic              tx_status;
    logic              frame_err;
    logic              overrun;

    modport master (
        input  rx_byte, rx_valid, tx_busy, alu_done, result,
        output tx_byte, tx_start, operAB, alu_start, rx_status, tx_status, frame_err, overrun
    );

    modport slave (
        output rx_byte, rx_valid, tx_busy, alu_done, result,
        input  tx_byte, tx_start, operAB, alu_start, rx_status, tx_status, frame_err, overrun
    );
endinterface

// File: rtl/uart_alu_frame_sequencer.sv
// Frame sequencer: collects N_IN RX bytes into operAB, kicks the adder, and
// streams the result back out through the TX core one byte at a time.
// Build macro CHECKSUM_EN: append one XOR-of-result byte after the result bytes.
//
// state      | meaning
// IDLE       | waiting for the first byte of a frame
// RX_COLLECT | collecting operand bytes, inter-byte timeout running
// ALU_REQ    | one-cycle alu_start pulse
// ALU_WAIT   | waiting for alu_done, result captured on it
// TX_LOAD    | waiting for TX idle, then issue tx_start for byte idx
// TX_ACK     | waiting for TX core to report busy
// TX_DRAIN   | waiting for TX core to finish, then next byte or done
module uart_alu_frame_sequencer #(
    parameter int OP_W        = 32,
    parameter int RES_W       = 32,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    uart_alu_frame_sequencer_if.master bus
);
    localparam int N_IN  = 2 * OP_W / 8;
    localparam int N_OUT = RES_W / 8;
`ifdef CHECKSUM_EN
    localparam int N_TX  = N_OUT + 1;
`else
    localparam int N_TX  = N_OUT;
`endif
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam int IDX_W = $clog2(N_TX + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, RX_COLLECT, ALU_REQ, ALU_WAIT, TX_LOAD, TX_ACK, TX_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [2*OP_W-1:0] oper_q, oper_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [7:0]        tx_sel;
    logic              tx_start_q, tx_start_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    // Byte to send for idx: a result byte, or past the last one the XOR checksum
    always_comb begin
        tx_sel = 8'h00;
`ifdef CHECKSUM_EN
        for (int i = 0; i < N_OUT; i++) tx_sel = tx_sel ^ res_q[8*i +: 8];
`endif
        for (int i = 0; i < N_OUT; i++) begin
            if (idx_q == IDX_W'(i)) tx_sel = res_q[8*i +: 8];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        oper_d      = oper_q;
        res_d       = res_q;
        tx_byte_d   = tx_byte_q;
        tx_start_d  = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    // Upper bytes of the previous frame are cleared together with byte 0
                    oper_d      = '0;
                    oper_d[7:0] = bus.rx_byte;
                    cnt_d       = CNT_W'(1);
                    tmo_d       = TMO_LOAD;
                    state_d     = RX_COLLECT;
                end
            end
            RX_COLLECT: begin
                // A byte arriving in the expiry cycle is taken ahead of the timeout
                if (bus.rx_valid) begin
                    for (int i = 1; i < N_IN; i++) begin
                        if (cnt_q == CNT_W'(i)) oper_d[8*i +: 8] = bus.rx_byte;
                    end
                    cnt_d = cnt_q + 1'b1;
                    tmo_d = TMO_LOAD;
                    if (cnt_q == CNT_W'(N_IN - 1)) state_d = ALU_REQ;
                end else if (tmo_q == '0) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            ALU_REQ: state_d = ALU_WAIT;
            ALU_WAIT: begin
                if (bus.alu_done) begin
                    res_d   = bus.result;
                    idx_d   = '0;
                    state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (!bus.tx_busy) begin
                    tx_byte_d  = tx_sel;
                    tx_start_d = 1'b1;
                    state_d    = TX_ACK;
                end
            end
            TX_ACK: begin
                if (bus.tx_busy) state_d = TX_DRAIN;
            end
            TX_DRAIN: begin
                if (!bus.tx_busy) begin
                    if (idx_q == IDX_W'(N_TX - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = TX_LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.rx_valid && (state_q inside {ALU_REQ, ALU_WAIT, TX_LOAD, TX_ACK, TX_DRAIN}))
            overrun_d = 1'b1;
    end

    // State and datapath registers
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            oper_q      <= '0;
            res_q       <= '0;
            tx_byte_q   <= '0;
            tx_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            oper_q      <= oper_d;
            res_q       <= res_d;
            tx_byte_q   <= tx_byte_d;
            tx_start_q  <= tx_start_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.operAB    = oper_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.alu_start = (state_q == ALU_REQ);
    assign bus.rx_status = (state_q == RX_COLLECT);
    assign bus.tx_status = (state_q inside {TX_LOAD, TX_ACK, TX_DRAIN});
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_alu_frame_sequencer.sv
// Directed bench for uart_alu_frame_sequencer with a byte scoreboard,
// a TX core stand-in and an adder stand-in.
module tb_uart_alu_frame_sequencer;
    localparam int TC       = 20;
    localparam int BUSY_CYC = 6;
`ifdef CHECKSUM_EN
    localparam int N_TX_EXP = 5;
`else
    localparam int N_TX_EXP = 4;
`endif

    logic sys_clk = 1'b0;
    logic rst     = 1'b0;
    always #5 sys_clk = ~sys_clk;

    uart_alu_frame_sequencer_if #(.OP_W(32), .RES_W(32)) bus ();

    uart_alu_frame_sequencer #(.OP_W(32), .RES_W(32), .TIMEOUT_CYC(TC)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_alu = 0;
    int n_tx  = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    logic [63:0] exp_op[$];
    logic [7:0]  exp_tx[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_frame(input logic [63:0] op);
        logic [31:0] r;
        r = op[63:32] + op[31:0];
        exp_op.push_back(op);
        for (int i = 0; i < 4; i++) exp_tx.push_back(r[8*i +: 8]);
`ifdef CHECKSUM_EN
        exp_tx.push_back(r[7:0] ^ r[15:8] ^ r[23:16] ^ r[31:24]);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(posedge sys_clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] op);
        expect_frame(op);
        for (int i = 0; i < 8; i++) send_byte(op[8*i +: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((exp_tx.size() != 0 || bus.tx_status !== 1'b0) && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        chk({tag, "_txq_left"}, 64'(exp_tx.size()), 64'd0);
        chk({tag, "_tx_status"}, 64'(bus.tx_status), 64'd0);
    endtask

    // TX core stand-in: scoreboard each tx_start, then a busy window
    initial begin
        logic [7:0] e;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (bus.tx_start === 1'b1) begin
                n_tx++;
                if (exp_tx.size() == 0) begin
                    chk("tx_spurious", 64'(bus.tx_start), 64'd0);
                end else begin
                    e = exp_tx.pop_front();
                    chk("tx_byte", 64'(bus.tx_byte), 64'(e));
                end
                @(posedge sys_clk); #1;
                bus.tx_busy = 1'b1;
                repeat (BUSY_CYC) @(posedge sys_clk);
                #1;
                bus.tx_busy = 1'b0;
            end
        end
    end

    // Adder stand-in: check operands on alu_start, return A+B a few cycles later
    initial begin
        logic [63:0] op;
        bus.alu_done = 1'b0;
        bus.result   = '0;
        forever begin
            @(negedge sys_clk);
            if (bus.alu_start === 1'b1) begin
                n_alu++;
                if (exp_op.size() == 0) begin
                    chk("alu_spurious", 64'(bus.alu_start), 64'd0);
                end else begin
                    op = exp_op.pop_front();
                    chk("operAB", bus.operAB, op);
                    repeat (3) @(posedge sys_clk);
                    #1;
                    bus.result   = op[63:32] + op[31:0];
                    bus.alu_done = 1'b1;
                    @(posedge sys_clk); #1;
                    bus.alu_done = 1'b0;
                end
            end
        end
    end

    // Pulse counters
    initial begin
        forever begin
            @(negedge sys_clk);
            if (bus.frame_err === 1'b1) n_ferr++;
            if (bus.overrun === 1'b1) n_ovr++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0, o0, t0, k;
        logic [63:0] op;
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_operAB", bus.operAB, 64'd0);
        chk("rst_tx_byte", 64'(bus.tx_byte), 64'd0);
        chk("rst_flags", 64'({bus.tx_start, bus.alu_start, bus.rx_status,
                              bus.tx_status, bus.frame_err, bus.overrun}), 64'd0);
        @(posedge sys_clk); #1;
        rst = 1'b1;

        // 1: 1+1, alu_start one cycle after last byte
        op = 64'h00000001_00000001;
        expect_frame(op);
        for (int i = 0; i < 8; i++) begin
            send_byte(op[8*i +: 8]);
            if (i == 0) chk("t1_rx_status", 64'(bus.rx_status), 64'd1);
        end
        @(negedge sys_clk);
        chk("t1_alu_latency", 64'(bus.alu_start), 64'd1);
        wait_idle("t1");
        chk("t1_alu_count", 64'(n_alu), 64'd1);
        chk("t1_operAB_hold", bus.operAB, op);

        // 2: all 0x55
        t0 = n_tx;
        send_frame(64'h55555555_55555555);
        wait_idle("t2");
        chk("t2_tx_count", 64'(n_tx - t0), 64'(N_TX_EXP));

        // 3: partial frame, exactly TC silent cycles
        f0 = n_ferr;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (TC - 1) begin @(posedge sys_clk); #1; end
        chk("t3_pre_expiry_rx_status", 64'(bus.rx_status), 64'd1);
        chk("t3_pre_expiry_frame_err", 64'(bus.frame_err), 64'd0);
        @(posedge sys_clk); #1;
        chk("t3_frame_err", 64'(bus.frame_err), 64'd1);
        chk("t3_rx_status", 64'(bus.rx_status), 64'd0);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("t3_frame_err_count", 64'(n_ferr - f0), 64'd1);
        send_frame(64'h00000001_00000001);
        wait_idle("t3_resync");

        // 4: byte lands in the expiry cycle
        f0 = n_ferr;
        op = 64'h87654321_00002010;
        expect_frame(op);
        send_byte(op[7:0]);
        repeat (TC - 2) begin @(posedge sys_clk); #1; end
        send_byte(op[15:8]);
        chk("t4_rx_status", 64'(bus.rx_status), 64'd1);
        chk("t4_no_frame_err", 64'(bus.frame_err), 64'd0);
        for (int i = 2; i < 8; i++) send_byte(op[8*i +: 8]);
        wait_idle("t4");
        chk("t4_frame_err_count", 64'(n_ferr - f0), 64'd0);

        // 5: rx byte during TX_DRAIN
        o0 = n_ovr;
        op = 64'h12345678_01020304;
        send_frame(op);
        k = 0;
        while (bus.tx_busy !== 1'b1 && k < 500) begin
            @(negedge sys_clk);
            k++;
        end
        chk("t5_busy_seen", 64'(bus.tx_busy), 64'd1);
        @(posedge sys_clk); #1;
        bus.rx_byte  = 8'h77;
        bus.rx_valid = 1'b1;
        @(posedge sys_clk); #1;
        bus.rx_valid = 1'b0;
        chk("t5_overrun", 64'(bus.overrun), 64'd1);
        chk("t5_operAB", bus.operAB, op);
        wait_idle("t5");
        chk("t5_overrun_count", 64'(n_ovr - o0), 64'd1);
        chk("t5_operAB_after", bus.operAB, op);

        // 6: reset during the second tx byte, then a clean frame
        t0 = n_tx;
        send_frame(64'h00000001_00000001);
        k = 0;
        while (n_tx - t0 < 2 && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        chk("t6_two_bytes_sent", 64'(n_tx - t0), 64'd2);
        @(posedge sys_clk); #1;
        rst = 1'b0;
        #1;
        chk("t6_rst_operAB", bus.operAB, 64'd0);
        chk("t6_rst_tx_byte", 64'(bus.tx_byte), 64'd0);
        chk("t6_rst_flags", 64'({bus.tx_start, bus.alu_start, bus.rx_status,
                                 bus.tx_status, bus.frame_err, bus.overrun}), 64'd0);
        exp_tx.delete();
        @(posedge sys_clk); #1;
        rst = 1'b1;
        repeat (BUSY_CYC + 2) @(posedge sys_clk);
        #1;
        t0 = n_tx;
        send_frame(64'h55555555_55555555);
        wait_idle("t6");
        chk("t6_tx_count", 64'(n_tx - t0), 64'(N_TX_EXP));
        chk("end_opq_left", 64'(exp_op.size()), 64'd0);
        chk("end_alu_count", 64'(n_alu), 64'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
